// File: rtl/reg_en_sequencer.sv
// Register-write-enable generator: decodes a register index into a registered one-hot
// enable and can walk a burst of consecutive registers (wrapping modulo N) with hold/abort.
module reg_en_sequencer #(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned MSB_FIRST = 1,
    localparam int unsigned N        = 2 ** SEL_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic [SEL_W-1:0] w,
    input  logic [SEL_W-1:0] len,
    input  logic             dir,
    input  logic             hold,
    input  logic             abort,
    output logic [N-1:0]     out,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] rem_q;
    logic             dir_q;
    logic [N-1:0]     out_q;
    logic             done_q;

    logic [SEL_W-1:0] idx_d;
    logic [SEL_W-1:0] rem_d;
    logic [SEL_W-1:0] pos_c;
    logic [N-1:0]     onehot_c;

    // Next index wraps naturally because the index is exactly SEL_W bits wide.
    always_comb begin
        idx_d = dir_q ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
        rem_d = rem_q - SEL_W'(1);
    end

    // Index-to-line mapping; with MSB_FIRST index 0 lands on the top line.
    always_comb begin
        pos_c    = (MSB_FIRST != 0) ? ~idx_q : idx_q;
        onehot_c = '0;
        onehot_c[pos_c] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_q  <= '0;
                    done_q <= 1'b0;
                    if (en) begin
                        idx_q   <= w;
                        rem_q   <= len;
                        dir_q   <= dir;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort wins over hold and over the final step.
                    if (abort) begin
                        out_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (hold) begin
                        out_q  <= '0;
                        done_q <= 1'b0;
                    end else begin
                        out_q  <= onehot_c;
                        idx_q  <= idx_d;
                        rem_q  <= rem_d;
                        done_q <= (rem_q == '0);
                        if (rem_q == '0) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    out_q   <= '0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign done  = done_q;
    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);

endmodule

// File: tb/tb_reg_en_sequencer.sv
// Directed bench for reg_en_sequencer: default 3-bit MSB-first instance plus a
// 4-bit LSB-first instance, checked with immediate assertions.
module tb_reg_en_sequencer;

    logic        clock;
    logic        resetn;

    logic        en0, dir0, hold0, abort0;
    logic [2:0]  w0, len0;
    logic [7:0]  out0;
    logic        ready0, busy0, done0;

    logic        en1, dir1, hold1, abort1;
    logic [3:0]  w1, len1;
    logic [15:0] out1;
    logic        ready1, busy1, done1;

    int n_asserts = 0;
    int n_fails   = 0;

    reg_en_sequencer u0 (
        .clock (clock), .resetn(resetn),
        .en    (en0),   .w     (w0),    .len  (len0), .dir (dir0),
        .hold  (hold0), .abort (abort0),
        .out   (out0),  .ready (ready0), .busy(busy0), .done(done0)
    );

    reg_en_sequencer #(.SEL_W(4), .MSB_FIRST(0)) u1 (
        .clock (clock), .resetn(resetn),
        .en    (en1),   .w     (w1),    .len  (len1), .dir (dir1),
        .hold  (hold1), .abort (abort1),
        .out   (out1),  .ready (ready1), .busy(busy1), .done(done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        en0 = 0; w0 = '0; len0 = '0; dir0 = 0; hold0 = 0; abort0 = 0;
        en1 = 0; w1 = '0; len1 = '0; dir1 = 0; hold1 = 0; abort1 = 0;
        #1;
        chk("rst_out",   16'(out0),   16'h0000);
        chk("rst_done",  16'(done0),  16'h0);
        chk("rst_ready", 16'(ready0), 16'h1);
        chk("rst_busy",  16'(busy0),  16'h0);
        tick(); tick();
        resetn = 1'b1;

        // Single-register burst at index 0
        en0 = 1; w0 = 3'd0; len0 = 3'd0; dir0 = 0;
        tick();
        chk("t1_busy",  16'(busy0),  16'h1);
        chk("t1_ready", 16'(ready0), 16'h0);
        chk("t1_out0",  16'(out0),   16'h0000);
        en0 = 0;
        tick();
        chk("t1_out",   16'(out0),   16'h0080);
        chk("t1_done",  16'(done0),  16'h1);
        tick();
        chk("t1_idle_out",   16'(out0),   16'h0000);
        chk("t1_idle_done",  16'(done0),  16'h0);
        chk("t1_idle_ready", 16'(ready0), 16'h1);

        // Back-to-back single bursts, one idle cycle apart
        en0 = 1; w0 = 3'd2; len0 = 3'd0;
        tick();
        w0 = 3'd5;
        tick();
        chk("bb_out_a",   16'(out0),   16'h0020);
        chk("bb_done_a",  16'(done0),  16'h1);
        chk("bb_ready_a", 16'(ready0), 16'h1);
        tick();
        chk("bb_gap_out",  16'(out0),  16'h0000);
        chk("bb_gap_busy", 16'(busy0), 16'h1);
        en0 = 0;
        tick();
        chk("bb_out_b",  16'(out0),  16'h0004);
        chk("bb_done_b", 16'(done0), 16'h1);
        tick();
        chk("bb_end_ready", 16'(ready0), 16'h1);

        // Incrementing burst wrapping 7 -> 0
        en0 = 1; w0 = 3'd6; len0 = 3'd3; dir0 = 0;
        tick();
        en0 = 0;
        tick();
        chk("t2_out_a",  16'(out0),  16'h0002);
        chk("t2_done_a", 16'(done0), 16'h0);
        tick();
        chk("t2_out_b",  16'(out0),  16'h0001);
        chk("t2_done_b", 16'(done0), 16'h0);
        tick();
        chk("t2_out_c",  16'(out0),  16'h0080);
        chk("t2_done_c", 16'(done0), 16'h0);
        tick();
        chk("t2_out_d",  16'(out0),  16'h0040);
        chk("t2_done_d", 16'(done0), 16'h1);
        tick();
        chk("t2_end_out",   16'(out0),   16'h0000);
        chk("t2_end_ready", 16'(ready0), 16'h1);

        // Decrementing burst with a hold, wrapping 0 -> 7
        en0 = 1; w0 = 3'd1; len0 = 3'd2; dir0 = 1;
        tick();
        en0 = 0; dir0 = 0;
        tick();
        chk("t3_out_a",  16'(out0),  16'h0040);
        chk("t3_done_a", 16'(done0), 16'h0);
        hold0 = 1;
        tick();
        chk("t3_hold_out",  16'(out0),  16'h0000);
        chk("t3_hold_done", 16'(done0), 16'h0);
        chk("t3_hold_busy", 16'(busy0), 16'h1);
        hold0 = 0;
        tick();
        chk("t3_out_b",  16'(out0),  16'h0080);
        chk("t3_done_b", 16'(done0), 16'h0);
        tick();
        chk("t3_out_c",  16'(out0),  16'h0001);
        chk("t3_done_c", 16'(done0), 16'h1);
        tick();
        chk("t3_end_ready", 16'(ready0), 16'h1);

        // Abort on the third burst cycle; en during RUN is ignored
        en0 = 1; w0 = 3'd0; len0 = 3'd7; dir0 = 0;
        tick();
        w0 = 3'd3;
        tick();
        chk("t4_out_a", 16'(out0), 16'h0080);
        tick();
        chk("t4_out_b",  16'(out0),  16'h0040);
        chk("t4_busy_b", 16'(busy0), 16'h1);
        en0 = 0; abort0 = 1;
        tick();
        chk("t4_abort_out",   16'(out0),   16'h0000);
        chk("t4_abort_done",  16'(done0),  16'h0);
        chk("t4_abort_ready", 16'(ready0), 16'h1);
        abort0 = 0;
        tick();
        chk("t4_after_out",  16'(out0),  16'h0000);
        chk("t4_after_done", 16'(done0), 16'h0);

        // Asynchronous reset mid-burst
        en0 = 1; w0 = 3'd4; len0 = 3'd5; dir0 = 0;
        tick();
        en0 = 0;
        tick();
        chk("t5_out_pre", 16'(out0), 16'h0008);
        #2 resetn = 1'b0;
        #1;
        chk("t5_rst_out",   16'(out0),   16'h0000);
        chk("t5_rst_done",  16'(done0),  16'h0);
        chk("t5_rst_ready", 16'(ready0), 16'h1);
        chk("t5_rst_busy",  16'(busy0),  16'h0);
        #2 resetn = 1'b1;
        en0 = 1; w0 = 3'd0; len0 = 3'd0;
        tick();
        en0 = 0;
        tick();
        chk("t5_restart_out",  16'(out0),  16'h0080);
        chk("t5_restart_done", 16'(done0), 16'h1);
        tick();

        // LSB-first 4-bit instance, wrapping 15 -> 0
        en1 = 1; w1 = 4'd15; len1 = 4'd1; dir1 = 0;
        tick();
        chk("t6_busy", 16'(busy1), 16'h1);
        en1 = 0;
        tick();
        chk("t6_out_a",  out1,          16'h8000);
        chk("t6_done_a", 16'(done1),    16'h0);
        tick();
        chk("t6_out_b",  out1,          16'h0001);
        chk("t6_done_b", 16'(done1),    16'h1);
        tick();
        chk("t6_end_out",   out1,         16'h0000);
        chk("t6_end_ready", 16'(ready1),  16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
